sram_ctrl: RTL

- Parametrised single-port SRAM block with a request/response interface.
- Adds per-byte write enables, a pipelined read with configurable latency (1 or 2), and a hardware clear sweep after reset, so contents are deterministic without a reset on the array.
- Sits between the sequencer/datapath logic and on-chip storage. It replaces the simple combinational-read memory.

---
 rtl/sram_pkg.sv | 41 ++++
 rtl/sram_array.sv | 45 ++++
 rtl/sram_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the sram_ctrl block.
//   - Default geometry and the derived DEPTH / NUM_BYTES / PAR_W.
//   - Controller state encoding.
//   - Byte-masked merge and per-byte parity helpers. Both work on a wide
//     scratch word, and callers size-cast to their real width.
// Optional feature macro: SRAM_PARITY_EN (PAR_W becomes NUM_BYTES).
package sram_pkg;
   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int BYTE_WIDTH_DEF = 8;
   localparam int DEPTH          = 2 ** ADDR_WIDTH_DEF;
   localparam int NUM_BYTES      = DATA_WIDTH_DEF / BYTE_WIDTH_DEF;
`ifdef SRAM_PARITY_EN
   localparam int PAR_W = NUM_BYTES;
`else
   localparam int PAR_W = 0;
`endif

   localparam int MAX_W = 256;
   typedef logic [MAX_W-1:0] word_t;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   // Bit i takes new_d when the enable for its lane (i / bw) is set.
   function automatic word_t byte_merge(input word_t old_d, input word_t new_d,
                                        input word_t be, input int bw);
      word_t r;
      for (int i = 0; i < MAX_W; i++)
         r[8'(i)] = be[8'(i / bw)] ? new_d[8'(i)] : old_d[8'(i)];
      return r;
   endfunction

   // Even parity per lane: bit b is the XOR of lane b's data bits.
   function automatic word_t byte_parity(input word_t d, input int bw);
      word_t p;
      p = '0;
      for (int i = 0; i < MAX_W; i++)
         p[8'(i / bw)] = p[8'(i / bw)] ^ d[8'(i)];
      return p;
   endfunction
endpackage

// File: rtl/sram_array.sv
// Storage for sram_ctrl. It has no reset, so its contents are established
// by the controller's clear sweep.
//   clk    : clock
//   we     : write strobe; only bytes with be set are written
//   re     : read strobe; rdata captures mem[addr] on this edge
//   addr   : word address
//   wdata  : write data
//   be     : byte enables
//   rdata  : registered read word, {parity, data} when parity is stored
// Optional feature macro: SRAM_PARITY_EN (adds PAR_W parity bits per word).
module sram_array
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
   parameter int PW         = 0
) (
   input  logic                              clk,
   input  logic                              we,
   input  logic                              re,
   input  logic [ADDR_WIDTH-1:0]             addr,
   input  logic [DATA_WIDTH-1:0]             wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  be,
   output logic [DATA_WIDTH+PW-1:0]          rdata
);
   localparam int SW = DATA_WIDTH + PW;
   localparam int DL = 1 << ADDR_WIDTH;

   logic [SW-1:0] mem [DL];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr][DATA_WIDTH-1:0] <= DATA_WIDTH'(byte_merge(
            word_t'(mem[addr][DATA_WIDTH-1:0]), word_t'(wdata), word_t'(be), BYTE_WIDTH));
`ifdef SRAM_PARITY_EN
         // Parity bits are one-bit lanes sharing the data byte enables.
         mem[addr][SW-1:DATA_WIDTH] <= PW'(byte_merge(
            word_t'(mem[addr][SW-1:DATA_WIDTH]),
            byte_parity(word_t'(wdata), BYTE_WIDTH), word_t'(be), 1));
`endif
      end
      if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM with a request/response interface, byte write enables,
// a read pipeline of RD_LATENCY (1 or 2) cycles, and a zeroing sweep after
// every reset.
//   clk, rst   : clock; asynchronous active-high reset
//   req_*      : request (valid/ready handshake, we, addr, wdata, be)
//   rsp_valid  : one-cycle pulse per read; rsp_rdata is 0 when it is low
//   init_done  : sweep finished, held until the next reset
//   rsp_perr   : parity error, aligned with rsp_valid (SRAM_PARITY_EN only)
// Optional feature macro: SRAM_PARITY_EN.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
   parameter int RD_LATENCY = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic                              req_we,
   input  logic [ADDR_WIDTH-1:0]             req_addr,
   input  logic [DATA_WIDTH-1:0]             req_wdata,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  req_be,
   output logic                              rsp_valid,
   output logic [DATA_WIDTH-1:0]             rsp_rdata,
   output logic                              init_done
`ifdef SRAM_PARITY_EN
  ,output logic                              rsp_perr
`endif
);
   localparam int NB = DATA_WIDTH / BYTE_WIDTH;
   localparam int PW = (PAR_W != 0) ? NB : 0;
   localparam int SW = DATA_WIDTH + PW;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic                    a_we, a_re;
   logic [ADDR_WIDTH-1:0]   a_addr;
   logic [DATA_WIDTH-1:0]   a_wdata;
   logic [NB-1:0]           a_be;
   logic [SW-1:0]           a_rdata, rd_word;
   logic [RD_LATENCY-1:0]   vld_pipe;

   // The sweep owns the array port in INIT; requests are held off by ready=0.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      init_done = 1'b0;
      a_we      = 1'b0;
      a_re      = 1'b0;
      a_addr    = req_addr;
      a_wdata   = req_wdata;
      a_be      = req_be;
      case (state)
         ST_INIT: begin
            a_we    = 1'b1;
            a_addr  = cnt;
            a_wdata = '0;
            a_be    = '1;
            if (&cnt) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            req_ready = 1'b1;
            init_done = 1'b1;
            a_we      = req_valid & req_we;
            a_re      = req_valid & ~req_we;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_INIT;
         cnt      <= '0;
         vld_pipe <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_INIT) cnt <= cnt + 1'b1;
         vld_pipe <= RD_LATENCY'({vld_pipe, a_re});
      end
   end

   sram_array #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
      .BYTE_WIDTH(BYTE_WIDTH), .PW(PW)
   ) u_array (
      .clk(clk), .we(a_we), .re(a_re), .addr(a_addr),
      .wdata(a_wdata), .be(a_be), .rdata(a_rdata)
   );

   // Data needs no reset: it is only visible while the (reset) valid bit is set.
   if (RD_LATENCY == 1) begin : g_lat1
      assign rd_word = a_rdata;
   end else if (RD_LATENCY == 2) begin : g_lat2
      logic [SW-1:0] rd_q;
      always_ff @(posedge clk) rd_q <= a_rdata;
      assign rd_word = rd_q;
   end else begin : g_bad_lat
      $error("sram_ctrl: RD_LATENCY must be 1 or 2");
   end

   always_comb begin
      rsp_valid = vld_pipe[RD_LATENCY-1];
      rsp_rdata = rsp_valid ? rd_word[DATA_WIDTH-1:0] : '0;
`ifdef SRAM_PARITY_EN
      rsp_perr  = rsp_valid & (|(rd_word[SW-1:DATA_WIDTH] ^
                  PW'(byte_parity(word_t'(rd_word[DATA_WIDTH-1:0]), BYTE_WIDTH))));
`endif
   end
endmodule
